// File: rtl/prm_edge_mask_accum.sv
// Frame-level collision accumulator: feeds voxel codes to the PRM checker bank and ORs the
// returned per-edge masks into a sticky blocked-edge vector presented once per frame.
//
// state | meaning
// ACCUM | accepting voxels, one per cycle
// FINAL | last voxel's mask in flight, capture result registers
// OUT   | result held for the planner until res_ready
module prm_edge_mask_accum #(
    parameter int NUM_EDGES = 64,
    parameter int CODE_W    = 15,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vox_valid,
    input  logic [CODE_W-1:0]    vox_code,
    input  logic                 vox_last,
    output logic                 vox_ready,
    output logic [CODE_W-1:0]    chk_code,
    input  logic [NUM_EDGES-1:0] chk_mask,
    output logic                 res_valid,
    output logic [NUM_EDGES-1:0] res_mask,
    output logic [CNT_W-1:0]     res_count,
    input  logic                 res_ready
);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FINAL = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CODE_W-1:0]      chk_code_q, chk_code_d;
    logic                   stage_v_q, stage_v_d;
    logic                   stage_last_q, stage_last_d;
    logic [NUM_EDGES-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   res_valid_q, res_valid_d;
    logic [NUM_EDGES-1:0]   res_mask_q, res_mask_d;
    logic [CNT_W-1:0]       res_count_q, res_count_d;
    logic                   vox_accept;

    always_comb begin
        state_d      = state_q;
        chk_code_d   = chk_code_q;
        stage_v_d    = 1'b0;
        stage_last_d = stage_last_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        res_valid_d  = res_valid_q;
        res_mask_d   = res_mask_q;
        res_count_d  = res_count_q;

        vox_ready  = (state_q == ST_ACCUM);
        vox_accept = vox_valid & vox_ready;

        if (stage_v_q) begin
            acc_d = acc_q | chk_mask;
        end

        if (vox_accept) begin
            chk_code_d   = vox_code;
            stage_v_d    = 1'b1;
            stage_last_d = vox_last;
            // Saturate rather than wrap so huge frames still report a sane count.
            cnt_d        = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_ACCUM: begin
                if (vox_accept && vox_last) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                if (stage_v_q && stage_last_q) begin
                    res_mask_d  = acc_q | chk_mask;
                    res_count_d = cnt_q;
                    state_d     = ST_OUT;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_OUT: begin
                // Valid rises one cycle after the result registers load, so the planner
                // only ever sees settled registered values.
                if (!res_valid_q) begin
                    res_valid_d = 1'b1;
                end else if (res_ready) begin
                    res_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    stage_v_d   = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACCUM;
            chk_code_q   <= '0;
            stage_v_q    <= 1'b0;
            stage_last_q <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            res_valid_q  <= 1'b0;
            res_mask_q   <= '0;
            res_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            chk_code_q   <= chk_code_d;
            stage_v_q    <= stage_v_d;
            stage_last_q <= stage_last_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            res_valid_q  <= res_valid_d;
            res_mask_q   <= res_mask_d;
            res_count_q  <= res_count_d;
        end
    end

    assign chk_code  = chk_code_q;
    assign res_valid = res_valid_q;
    assign res_mask  = res_mask_q;
    assign res_count = res_count_q;

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Bench for prm_edge_mask_accum: 4-edge behavioural checker bank, frame-level reference model
// (OR of code bits, saturating voxel count) and explicit latency/backpressure scenarios.
module tb_prm_edge_mask_accum;

    localparam int NE = 4;
    localparam int CW = 15;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          vox_valid;
    logic [CW-1:0] vox_code;
    logic          vox_last;
    logic          vox_ready;
    logic [CW-1:0] chk_code;
    logic [NE-1:0] chk_mask;
    logic          res_valid;
    logic [NE-1:0] res_mask;
    logic [NW-1:0] res_count;
    logic          res_ready;

    int tot = 0;
    int bad = 0;

    prm_edge_mask_accum #(.NUM_EDGES(NE), .CODE_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst),
        .vox_valid(vox_valid), .vox_code(vox_code), .vox_last(vox_last), .vox_ready(vox_ready),
        .chk_code(chk_code), .chk_mask(chk_mask),
        .res_valid(res_valid), .res_mask(res_mask), .res_count(res_count), .res_ready(res_ready)
    );

    assign chk_mask = chk_code[NE-1:0];

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [NW-1:0] sat_count(input int n);
        return (n > 65535) ? 16'hFFFF : NW'(n);
    endfunction

    // Starts and ends at a negedge; returns once the voxel has been accepted.
    task automatic push_voxel(input logic [CW-1:0] code, input logic last);
        int g = 0;
        vox_valid = 1'b1;
        vox_code  = code;
        vox_last  = last;
        while (!vox_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!vox_ready) begin
            tot++; bad++;
            $display("FAIL accept_timeout: got vox_ready=0 want 1");
        end
        @(posedge clk);
        @(negedge clk);
        vox_valid = 1'b0;
    endtask

    task automatic wait_result(input logic [NE-1:0] em, input int n, input string name);
        int g = 0;
        while (!res_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        tot++;
        if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_valid: got %b want 1", name, res_valid);
        end
        tot++;
        if (res_mask !== em) begin
            bad++;
            $display("FAIL %s_mask: got %b want %b", name, res_mask, em);
        end
        tot++;
        if (res_count !== sat_count(n)) begin
            bad++;
            $display("FAIL %s_count: got %0h want %0h", name, res_count, sat_count(n));
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; vox_valid = 1'b1; vox_code = 15'h7FFF; vox_last = 1'b1; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        tot++;
        if (chk_code !== '0) begin bad++; $display("FAIL rst_chk_code: got %0h want 0", chk_code); end
        tot++;
        if (res_valid !== 1'b0 || res_mask !== '0 || res_count !== '0) begin
            bad++;
            $display("FAIL rst_result: got v=%b m=%b c=%0h want 0/0/0", res_valid, res_mask, res_count);
        end
        rst = 1'b0; vox_valid = 1'b0; vox_last = 1'b0;
        tot++;
        if (vox_ready !== 1'b1) begin bad++; $display("FAIL rst_vox_ready: got %b want 1", vox_ready); end
        @(negedge clk);
        tot++;
        if (res_valid !== 1'b0 || chk_code !== '0) begin
            bad++;
            $display("FAIL rst_idle: got v=%b code=%0h want 0/0", res_valid, chk_code);
        end
    endtask

    task automatic test_single;
        logic [3:0] seen_v;
        logic [3:0] seen_r;
        res_ready = 1'b1;
        push_voxel(15'h0005, 1'b1);
        // Now just after edge t; sample after t, t+1, t+2, t+3.
        for (int k = 0; k < 4; k++) begin
            seen_v[k] = res_valid;
            seen_r[k] = vox_ready;
            if (k == 2) begin
                tot++;
                if (res_mask !== 4'b0101 || res_count !== 16'd1) begin
                    bad++;
                    $display("FAIL single_result: got m=%b c=%0d want 0101/1", res_mask, res_count);
                end
            end
            if (k < 3) @(negedge clk);
        end
        tot++;
        if (seen_v !== 4'b0100) begin bad++; $display("FAIL single_valid_timing: got %b want 0100", seen_v); end
        tot++;
        if (seen_r !== 4'b1000) begin bad++; $display("FAIL single_ready_timing: got %b want 1000", seen_r); end
        tot++;
        if (res_mask !== 4'b0101 || res_count !== 16'd1) begin
            bad++;
            $display("FAIL single_hold_after: got m=%b c=%0d want 0101/1", res_mask, res_count);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        push_voxel(15'h0001, 1'b0);
        push_voxel(15'h0002, 1'b0);
        push_voxel(15'h0008, 1'b1);
        wait_result(4'b1011, 3, "b2b");
        push_voxel(15'h0004, 1'b1);
        wait_result(4'b0100, 1, "b2b_next");
    endtask

    task automatic test_backpressure;
        int g = 0;
        push_voxel(15'h0003, 1'b1);
        while (!res_valid && g < 50) begin @(negedge clk); g++; end
        vox_valid = 1'b1; vox_code = 15'h000F; vox_last = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tot++;
            if (vox_ready !== 1'b0 || res_valid !== 1'b1 || res_mask !== 4'b0011 || res_count !== 16'd1) begin
                bad++;
                $display("FAIL bp_hold: got rdy=%b v=%b m=%b c=%0d want 0/1/0011/1",
                         vox_ready, res_valid, res_mask, res_count);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        tot++;
        if (vox_ready !== 1'b1 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: got rdy=%b v=%b want 1/0", vox_ready, res_valid);
        end
        push_voxel(15'h000F, 1'b0);
        push_voxel(15'h0000, 1'b1);
        wait_result(4'b1111, 2, "bp_next");
    endtask

    task automatic test_gapped;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        push_voxel(15'h0010, 1'b0);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        push_voxel(15'h0004, 1'b1);
        wait_result(4'b0100, 2, "gapped");
    endtask

    task automatic test_random;
        for (int f = 0; f < 15; f++) begin
            int n;
            logic [NE-1:0] em;
            logic [CW-1:0] code;
            n  = $urandom_range(1, 8);
            em = '0;
            for (int v = 0; v < n; v++) begin
                code = CW'($urandom);
                em   = em | code[NE-1:0];
                repeat ($urandom_range(0, 2)) @(negedge clk);
                push_voxel(code, (v == n - 1));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wait_result(em, n, "random");
        end
    endtask

    task automatic test_saturation;
        for (int v = 0; v < 70000; v++) push_voxel(15'h0000, 1'b0);
        push_voxel(15'h0001, 1'b1);
        wait_result(4'b0001, 70001, "sat");
    endtask

    task automatic test_mid_reset;
        int seen = 0;
        for (int v = 0; v < 3; v++) push_voxel(15'h000F, 1'b0);
        rst = 1'b1; vox_valid = 1'b1; vox_code = 15'h000F; vox_last = 1'b1;
        @(negedge clk);
        rst = 1'b0; vox_valid = 1'b0; vox_last = 1'b0;
        tot++;
        if (chk_code !== '0 || vox_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_state: got code=%0h rdy=%b want 0/1", chk_code, vox_ready);
        end
        for (int k = 0; k < 5; k++) begin
            if (res_valid) seen++;
            @(negedge clk);
        end
        tot++;
        if (seen != 0) begin bad++; $display("FAIL midrst_no_result: got %0d valid cycles want 0", seen); end
        push_voxel(15'h0002, 1'b1);
        wait_result(4'b0010, 1, "midrst_next");
    endtask

    initial begin
        rst = 1'b1; vox_valid = 1'b0; vox_code = '0; vox_last = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        test_reset;
        test_single;
        test_back_to_back;
        test_backpressure;
        test_gapped;
        test_random;
        test_saturation;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule

// File: doc/prm_edge_mask_accum.md
# prm_edge_mask_accum

Frame-level collision accumulator that sits directly downstream of the PRM obstacle-logic checker bank (the `prm_oblgc_chk*` instances, one per roadmap edge). It accepts a stream of occupied-voxel codes for one obstacle frame and drives each code onto the shared 15-bit checker input bus. It ORs the returned per-edge `edge_mask` bits into a sticky blocked-edge vector. At end of frame it presents the final vector, plus a voxel count, to the roadmap planner over a valid/ready handshake.

## Interface
Parameters:
- `NUM_EDGES`, 64: number of checker instances. This is the width of the mask vectors.
- `CODE_W`, 15: voxel code width. Fixed by the checker input letters A..O.
- `CNT_W`, 16: width of the voxel counter.

Ports:
- `clk`  in  1  single clock. All logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `vox_valid`  in  1  voxel code available.
- `vox_code`  in  CODE_W  occupied-voxel code.
- `vox_last`  in  1  marks the final voxel of the frame. Qualified by `vox_valid`.
- `vox_ready`  out  1  block accepts a voxel this cycle.
- `chk_code`  out  CODE_W  registered code to the checker bank. Bit 0 = A … bit 14 = O.
- `chk_mask`  in  NUM_EDGES  combinational checker outputs for `chk_code`. Bit i = edge_mask of checker i.
- `res_valid`  out  1  result available.
- `res_mask`  out  NUM_EDGES  1 = edge blocked by at least one voxel in the frame.
- `res_count`  out  CNT_W  voxels accepted in the frame. Saturating.
- `res_ready`  in  1  consumer takes the result.

## Operation
- Voxel accept is defined as `vox_valid & vox_ready` at a rising edge. On accept:
  - `chk_code` <= `vox_code`
  - `stage_v` <= 1
  - `stage_last` <= `vox_last`
  - `cnt` <= `cnt`+1
- With no accept, `stage_v` <= 0 and `chk_code` holds its value.
- Accumulate: on any cycle with `stage_v`=1, `acc` <= `acc` | `chk_mask`. `chk_mask` is ignored when `stage_v`=0.
- Counter arithmetic: `cnt` is CNT_W bits and saturates at all-ones (0xFFFF). It never wraps.
- The state machine has three states; reset state is ACCUM:
  - ACCUM:
    - `vox_ready`=1.
    - An accept with `vox_last`=1 moves to FINAL.
    - Otherwise stay in ACCUM.
  - FINAL:
    - `vox_ready`=0.
    - The last voxel's mask is in flight (`stage_v`=1).
    - `res_mask` <= `acc` | `chk_mask`; `res_count` <= `cnt`.
    - Move to OUT.
  - OUT:
    - `vox_ready`=0 and `res_valid`=1; `res_mask` and `res_count` are stable.
    - On `res_ready`=1: clear `acc`, `cnt` and `stage_v`, then return to ACCUM.
    - `res_mask` and `res_count` keep their values after the handshake until the next FINAL.
- A frame always contains at least one voxel, because `vox_last` rides on a valid voxel. A one-voxel frame is legal.
- A voxel presented while `vox_ready`=0 is not consumed. The upstream source holds it.

## Timing
- Reset values:
  - State = ACCUM.
  - `chk_code`=0, `stage_v`=0, `stage_last`=0.
  - `acc`=0 and `cnt`=0.
  - `res_valid`=0, `res_mask`=0, `res_count`=0.
  - `vox_ready`=1 in the first cycle after reset release.
- Throughput is one voxel per cycle in ACCUM, back to back.
- Latency: for a last voxel accepted at edge t, the FINAL state runs in cycle t..t+1 and `res_valid` rises after edge t+2.
- The checker path is `chk_code` register → bank → `chk_mask` → `acc` register. It is one full cycle and is the critical path.
- In OUT, `res_valid`, `res_mask` and `res_count` must not change until a `res_ready` handshake.
- With `res_ready` held at 1, the first voxel of the next frame is accepted at edge t+4.
  - Minimum inter-frame gap is 3 cycles with `vox_ready`=0.
- If `rst` is asserted mid-frame or in OUT, the partial frame or pending result is discarded.
  - All state returns to reset values on the next edge.
  - No result is produced for the aborted frame.
- When `rst` and `vox_valid` are high together, reset wins and the voxel is not accepted.

## Test plan
Bench settings: `NUM_EDGES`=4, behavioural bank `chk_mask` = `chk_code[3:0]`.

1. Single-voxel frame:
   - Stimulus: code 0x0005 with last=1, `res_ready`=1.
   - Required: `res_valid` rises after edge t+2, `res_mask`=4'b0101, `res_count`=1, `vox_ready` returns to 1 at t+3.
2. Back-to-back frame:
   - Stimulus: codes 0x0001, 0x0002, 0x0008 on consecutive cycles, last on 0x0008.
   - Required: `res_mask`=4'b1011, `res_count`=3, and no stale bits carried into the next frame.
3. Result backpressure:
   - Stimulus: `res_ready`=0 for 10 cycles in OUT while `vox_valid`=1 with code 0x000F.
   - Required: `vox_ready`=0 throughout, and `res_mask`/`res_count` are stable.
   - After `res_ready`=1, code 0x000F is accepted and becomes the first voxel of the next frame; `res_count` of the next frame counts it.
4. Gapped input:
   - Stimulus: voxels with random `vox_valid` gaps, codes 0x0010 and 0x0004.
   - Required: `res_mask`=4'b0100 (0x0010 contributes nothing), `res_count`=2.
5. Counter saturation:
   - Stimulus: 70000 voxels of code 0 followed by a last voxel of code 0x0001.
   - Required: `res_count`=0xFFFF, `res_mask`=4'b0001.
6. Mid-frame reset:
   - Stimulus: 3 voxels of 0x000F, `rst` for 1 cycle, then a single-voxel frame of 0x0002.
   - Required: no result for the aborted frame; next `res_mask`=4'b0010, `res_count`=1.
